// File: rtl/data_mem_responder_if.sv
// Request/response bus between a memory master and data_mem_responder.
// Mixed-case names match the Mem_Read/Mem_Write/Mem_Addr/Write_Data interface they sit on.
interface data_mem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        Mem_Read;
   logic        Mem_Write;
   logic [63:0] Mem_Addr;
   logic [63:0] Write_Data;
   logic        resp_valid;
   logic        resp_err;
   logic [63:0] Read_Data;

   modport master (
      output req_valid, Mem_Read, Mem_Write, Mem_Addr, Write_Data,
      input  req_ready, resp_valid, resp_err, Read_Data
   );

   modport slave (
      input  req_valid, Mem_Read, Mem_Write, Mem_Addr, Write_Data,
      output req_ready, resp_valid, resp_err, Read_Data
   );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding doubleword memory responder with programmable wait states.
// DEPTH must be at least 8 so that all debug taps map onto real words.
module data_mem_responder #(
   parameter int unsigned DEPTH       = 10,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   data_mem_responder_if.slave  bus,
   output logic [63:0]          dbg_word0,
   output logic [63:0]          dbg_word1,
   output logic [63:0]          dbg_word2,
   output logic [63:0]          dbg_word3,
   output logic [63:0]          dbg_word4,
   output logic [63:0]          dbg_word5,
   output logic [63:0]          dbg_word6,
   output logic [63:0]          dbg_word7
);
   localparam int unsigned DATA_W    = 64;
   localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]  WAIT_LOAD = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t state;
   state_t next_state;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [3:0]        cnt;
   logic              rd_q;
   logic              wr_q;
   logic              err_q;
   logic [IDX_W-1:0]  idx_q;
   logic [DATA_W-1:0] wdata_q;

   logic              accept_c;
   logic              req_err_c;
   logic [IDX_W-1:0]  req_idx_c;
   logic              sel_err_c;
   logic              sel_rd_c;
   logic [IDX_W-1:0]  sel_idx_c;

   // Legality of the request currently presented on the bus
   always_comb begin
      req_err_c = (bus.Mem_Addr[2:0] != 3'b000)
               || (bus.Mem_Addr[63:3] >= 61'(DEPTH))
               || (bus.Mem_Read == bus.Mem_Write);
      req_idx_c = IDX_W'(bus.Mem_Addr[63:3]);
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      accept_c   = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (bus.req_valid && bus.req_ready) begin
               accept_c   = 1'b1;
               next_state = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt == 4'd0) begin
               next_state = S_RESP;
            end
         end
         S_RESP:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // With zero wait states RESP is entered straight from the accept, before the latches fill
   always_comb begin
      sel_err_c = (state == S_IDLE) ? req_err_c     : err_q;
      sel_rd_c  = (state == S_IDLE) ? bus.Mem_Read  : rd_q;
      sel_idx_c = (state == S_IDLE) ? req_idx_c     : idx_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Request latches, wait counter and registered response outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt            <= 4'd0;
         rd_q           <= 1'b0;
         wr_q           <= 1'b0;
         err_q          <= 1'b0;
         idx_q          <= '0;
         wdata_q        <= '0;
         bus.req_ready  <= 1'b0;
         bus.resp_valid <= 1'b0;
         bus.resp_err   <= 1'b0;
         bus.Read_Data  <= '0;
      end else begin
         bus.req_ready  <= (next_state == S_IDLE);
         bus.resp_valid <= (next_state == S_RESP);
         bus.resp_err   <= 1'b0;
         if (accept_c) begin
            rd_q    <= bus.Mem_Read;
            wr_q    <= bus.Mem_Write;
            err_q   <= req_err_c;
            idx_q   <= req_idx_c;
            wdata_q <= bus.Write_Data;
            cnt     <= WAIT_LOAD;
         end else if (state == S_WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         if (next_state == S_RESP) begin
            bus.resp_err <= sel_err_c;
            if (sel_err_c) begin
               bus.Read_Data <= '0;
            end else if (sel_rd_c) begin
               bus.Read_Data <= mem[sel_idx_c];
            end
         end
      end
   end

   // Storage array: descending reset pattern, writes commit during RESP
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned k = 0; k < DEPTH; k++) begin
            mem[k] <= 64'(DEPTH - k);
         end
      end else if (state == S_RESP && wr_q && !err_q) begin
         mem[idx_q] <= wdata_q;
      end
   end

   assign dbg_word0 = mem[0];
   assign dbg_word1 = mem[1];
   assign dbg_word2 = mem[2];
   assign dbg_word3 = mem[3];
   assign dbg_word4 = mem[4];
   assign dbg_word5 = mem[5];
   assign dbg_word6 = mem[6];
   assign dbg_word7 = mem[7];
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed + randomized bench for data_mem_responder against a word-array reference model.
module tb_data_mem_responder;
   localparam int unsigned DEPTH       = 10;
   localparam int unsigned WAIT_CYCLES = 1;
   localparam int          LAT         = WAIT_CYCLES + 1;

   logic clk     = 1'b0;
   logic reset_n = 1'b1;
   always #5 clk = ~clk;

   data_mem_responder_if bus ();
   logic [63:0] dbg_word0, dbg_word1, dbg_word2, dbg_word3;
   logic [63:0] dbg_word4, dbg_word5, dbg_word6, dbg_word7;

   data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus),
      .dbg_word0(dbg_word0), .dbg_word1(dbg_word1), .dbg_word2(dbg_word2), .dbg_word3(dbg_word3),
      .dbg_word4(dbg_word4), .dbg_word5(dbg_word5), .dbg_word6(dbg_word6), .dbg_word7(dbg_word7)
   );

   typedef struct {
      logic        rd;
      logic        wr;
      logic [63:0] addr;
      logic [63:0] wdata;
      int          cyc;
   } req_t;

   int          total = 0;
   int          bad   = 0;
   logic [63:0] model [DEPTH];
   logic [63:0] model_last;
   req_t        pend [$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] dbg_at(input int k);
      case (k)
         0: return dbg_word0;
         1: return dbg_word1;
         2: return dbg_word2;
         3: return dbg_word3;
         4: return dbg_word4;
         5: return dbg_word5;
         6: return dbg_word6;
         default: return dbg_word7;
      endcase
   endfunction

   task automatic model_reset();
      for (int k = 0; k < DEPTH; k++) model[k] = 64'(DEPTH - k);
      model_last = '0;
   endtask

   // Reference: apply one request to the word array, return expected err/data
   task automatic model_apply(input logic rd, input logic wr, input logic [63:0] addr,
                              input logic [63:0] wdata, output logic e, output logic [63:0] d);
      e = (addr % 8 != 0) || (addr / 8 >= DEPTH) || (rd == wr);
      if (e) begin
         d = '0;
         model_last = '0;
      end else if (rd) begin
         d = model[addr / 8];
         model_last = d;
      end else begin
         d = model_last;
         model[addr / 8] = wdata;
      end
   endtask

   task automatic check_dbg(input string tag);
      for (int k = 0; k < 8; k++) check($sformatf("%s_dbg%0d", tag, k), dbg_at(k), model[k]);
   endtask

   // One full handshake; inputs are scrambled right after accept
   task automatic do_req(input logic rd, input logic wr, input logic [63:0] addr,
                         input logic [63:0] wdata, output logic [63:0] rdata);
      int          n;
      logic        e;
      logic [63:0] d;
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.Mem_Read   = rd;
      bus.Mem_Write  = wr;
      bus.Mem_Addr   = addr;
      bus.Write_Data = wdata;
      n = 0;
      while (bus.req_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("accept_wait", 64'(n < 50), 64'd1);
      @(posedge clk);
      #1;
      bus.req_valid  = 1'b0;
      bus.Mem_Read   = 1'($urandom);
      bus.Mem_Write  = 1'($urandom);
      bus.Mem_Addr   = {$urandom, $urandom};
      bus.Write_Data = {$urandom, $urandom};
      model_apply(rd, wr, addr, wdata, e, d);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.resp_valid !== 1'b1 && n < 20);
      check("latency", 64'(n), 64'(LAT));
      check("resp_err", 64'(bus.resp_err), 64'(e));
      check("read_data", bus.Read_Data, d);
      rdata = bus.Read_Data;
      @(negedge clk);
      check("resp_pulse", 64'(bus.resp_valid), 64'd0);
      if (wr && !e) check_dbg("post_wr");
   endtask

   // Streaming-phase response checker
   task automatic handle_resp(input int cyc);
      req_t        it;
      logic        e;
      logic [63:0] d;
      if (bus.resp_valid === 1'b1) begin
         if (pend.size() == 0) begin
            check("t4_spurious_resp", 64'd1, 64'd0);
         end else begin
            it = pend.pop_front();
            model_apply(it.rd, it.wr, it.addr, it.wdata, e, d);
            check("t4_latency", 64'(cyc - it.cyc), 64'(LAT));
            check("t4_err", 64'(bus.resp_err), 64'(e));
            check("t4_data", bus.Read_Data, d);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] a, b, tmp;
      int          last_acc, n_acc, r;

      bus.req_valid  = 1'b0;
      bus.Mem_Read   = 1'b0;
      bus.Mem_Write  = 1'b0;
      bus.Mem_Addr   = '0;
      bus.Write_Data = '0;
      model_reset();

      // Reset state
      #1 reset_n = 1'b0;
      #20;
      check("rst_ready", 64'(bus.req_ready), 64'd0);
      check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      check("rst_resp_err", 64'(bus.resp_err), 64'd0);
      check("rst_read_data", bus.Read_Data, 64'd0);
      check_dbg("rst");
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("ready_after_rst", 64'(bus.req_ready), 64'd1);

      // 1: read word 0
      do_req(1'b1, 1'b0, 64'd0, 64'd0, a);
      check("t1_word0", a, 64'd10);

      // 2: write then read back word 1
      do_req(1'b0, 1'b1, 64'd8, 64'h5, tmp);
      check("t2_dbg1", dbg_word1, 64'd5);
      do_req(1'b1, 1'b0, 64'd8, 64'd0, a);
      check("t2_read_back", a, 64'd5);

      // 3: illegal requests leave memory untouched
      do_req(1'b1, 1'b0, 64'h4, 64'd0, tmp);
      do_req(1'b1, 1'b0, 64'd80, 64'd0, tmp);
      do_req(1'b1, 1'b1, 64'd0, 64'hDEAD, tmp);
      do_req(1'b0, 1'b0, 64'd16, 64'hBEEF, tmp);
      do_req(1'b0, 1'b1, 64'h1000_0000_0000_0000, 64'hBAD, tmp);
      check("t3_dbg0", dbg_word0, 64'd10);
      check_dbg("t3");

      // 4: req_valid held high with a new random request every cycle
      last_acc = -1000;
      n_acc    = 0;
      for (int cyc = 0; cyc < 240; cyc++) begin
         @(negedge clk);
         handle_resp(cyc);
         if (cyc < 200) begin
            r = int'($urandom_range(0, 9));
            bus.req_valid  = 1'b1;
            bus.Mem_Read   = (r < 5) || (r == 9);
            bus.Mem_Write  = (r >= 5);
            bus.Mem_Addr   = 64'($urandom_range(0, 11) * 8 + (($urandom_range(0, 7) == 0) ? 4 : 0));
            bus.Write_Data = {$urandom, $urandom};
            if (bus.req_ready === 1'b1) begin
               if (n_acc > 0) check("t4_accept_spacing", 64'(cyc - last_acc), 64'(LAT + 1));
               pend.push_back('{bus.Mem_Read, bus.Mem_Write, bus.Mem_Addr, bus.Write_Data, cyc});
               last_acc = cyc;
               n_acc++;
            end
         end else begin
            bus.req_valid = 1'b0;
         end
      end
      check("t4_drained", 64'(pend.size()), 64'd0);
      check("t4_enough_accepts", 64'(n_acc >= 40), 64'd1);
      check_dbg("t4");

      // 5: reset during the wait state of a write
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.Mem_Read   = 1'b0;
      bus.Mem_Write  = 1'b1;
      bus.Mem_Addr   = 64'd16;
      bus.Write_Data = 64'hFF;
      r = 0;
      while (bus.req_ready !== 1'b1 && r < 50) begin
         @(negedge clk);
         r++;
      end
      check("t5_accept_wait", 64'(r < 50), 64'd1);
      @(posedge clk);
      #2 bus.req_valid = 1'b0;
      reset_n = 1'b0;
      model_reset();
      #1;
      check("t5_ready_in_rst", 64'(bus.req_ready), 64'd0);
      check("t5_rdata_in_rst", bus.Read_Data, 64'd0);
      check("t5_dbg2_in_rst", dbg_word2, 64'd8);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check("t5_no_resp_rst", 64'(bus.resp_valid), 64'd0);
      end
      reset_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("t5_no_resp_after", 64'(bus.resp_valid), 64'd0);
      end
      check("t5_dbg2", dbg_word2, 64'd8);
      check_dbg("t5");

      // 6: bubble sort through the handshake
      for (int i = 0; i < DEPTH - 1; i++) begin
         for (int j = 0; j < DEPTH - 1 - i; j++) begin
            do_req(1'b1, 1'b0, 64'(8 * j), 64'd0, a);
            do_req(1'b1, 1'b0, 64'(8 * (j + 1)), 64'd0, b);
            if (a > b) begin
               do_req(1'b0, 1'b1, 64'(8 * j), b, tmp);
               do_req(1'b0, 1'b1, 64'(8 * (j + 1)), a, tmp);
            end
         end
      end
      for (int k = 0; k < 8; k++) check($sformatf("t6_sorted%0d", k), dbg_at(k), 64'(k + 1));
      do_req(1'b1, 1'b0, 64'd64, 64'd0, a);
      check("t6_word8", a, 64'd9);
      do_req(1'b1, 1'b0, 64'd72, 64'd0, a);
      check("t6_word9", a, 64'd10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
